srt_div_sched: RTL and testbench

//  Round-robin scheduler that shares one SRT divider core among NREQ requesters.

---
 rtl/srt_div_sched.sv | 183 ++++++++++++++++++
 tb/tb_srt_div_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srt_div_sched.sv
// Round-robin front end that time-shares a single SRT divider core among NREQ requesters.
// Divide-by-zero and core timeouts are resolved here without involving the core.
module srt_div_sched #(
   parameter int NREQ = 4,
   parameter int W    = 64,
   parameter int TMO  = 200,
   parameter int IDW  = 2
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic [NREQ-1:0]   REQ_V,
   output logic [NREQ-1:0]   REQ_RDY,
   input  logic [NREQ*W-1:0] REQ_DVD,
   input  logic [NREQ*W-1:0] REQ_DSR,
   output logic              DIV_START,
   output logic [W-1:0]      DIV_DVD,
   output logic [W-1:0]      DIV_DSR,
   input  logic              DIV_DONE,
   input  logic [W-1:0]      DIV_Q,
   input  logic [W-1:0]      DIV_R,
   output logic              RSP_V,
   input  logic              RSP_RDY,
   output logic [IDW-1:0]    RSP_ID,
   output logic [W-1:0]      RSP_Q,
   output logic [W-1:0]      RSP_R,
   output logic              RSP_DZ,
   output logic              RSP_TO,
   output logic              BUSY
);

   localparam int TW = $clog2(TMO) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t         state_reg, state_next;
   logic [IDW-1:0] rr_reg, rr_next;
   logic [IDW-1:0] id_reg, id_next;
   logic [W-1:0]   dvd_reg, dvd_next;
   logic [W-1:0]   dsr_reg, dsr_next;
   logic [TW-1:0]  timer_reg, timer_next;
   logic [W-1:0]   q_reg, q_next;
   logic [W-1:0]   r_reg, r_next;
   logic           dz_reg, dz_next;
   logic           to_reg, to_next;

   logic [W-1:0]   dvd_arr [NREQ];
   logic [W-1:0]   dsr_arr [NREQ];
   logic           any_req;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] cand_idx;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign dvd_arr[gi] = REQ_DVD[gi*W +: W];
         assign dsr_arr[gi] = REQ_DSR[gi*W +: W];
      end
   endgenerate

   // First active requester at or after the rr pointer, wrapping around.
   always_comb begin
      any_req   = 1'b0;
      grant_idx = '0;
      cand_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_idx = IDW'((int'(rr_reg) + k) % NREQ);
         if (!any_req && REQ_V[cand_idx]) begin
            any_req   = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   always_comb begin
      REQ_RDY = '0;
      if (state_reg == IDLE && any_req && RSTN)
         REQ_RDY[grant_idx] = 1'b1;
   end

   always_comb begin
      state_next = state_reg;
      rr_next    = rr_reg;
      id_next    = id_reg;
      dvd_next   = dvd_reg;
      dsr_next   = dsr_reg;
      timer_next = timer_reg;
      q_next     = q_reg;
      r_next     = r_reg;
      dz_next    = dz_reg;
      to_next    = to_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               id_next  = grant_idx;
               dvd_next = dvd_arr[grant_idx];
               dsr_next = dsr_arr[grant_idx];
               if (int'(grant_idx) == NREQ - 1)
                  rr_next = '0;
               else
                  rr_next = grant_idx + IDW'(1);
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            timer_next = '0;
            // A zero divisor never reaches the core; the answer is known already.
            if (dsr_reg == '0) begin
               q_next     = '1;
               r_next     = dvd_reg;
               dz_next    = 1'b1;
               to_next    = 1'b0;
               state_next = RESP;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (timer_reg != '1)
               timer_next = timer_reg + TW'(1);
            if (DIV_DONE) begin
               q_next     = DIV_Q;
               r_next     = DIV_R;
               dz_next    = 1'b0;
               to_next    = 1'b0;
               state_next = RESP;
            end else if (int'(timer_reg) >= TMO - 2) begin
               q_next     = '0;
               r_next     = '0;
               dz_next    = 1'b0;
               to_next    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (RSP_RDY)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_reg <= IDLE;
         rr_reg    <= '0;
         id_reg    <= '0;
         dvd_reg   <= '0;
         dsr_reg   <= '0;
         timer_reg <= '0;
         q_reg     <= '0;
         r_reg     <= '0;
         dz_reg    <= 1'b0;
         to_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         rr_reg    <= rr_next;
         id_reg    <= id_next;
         dvd_reg   <= dvd_next;
         dsr_reg   <= dsr_next;
         timer_reg <= timer_next;
         q_reg     <= q_next;
         r_reg     <= r_next;
         dz_reg    <= dz_next;
         to_reg    <= to_next;
      end
   end

   assign DIV_START = (state_reg == ISSUE) && (dsr_reg != '0);
   assign DIV_DVD   = dvd_reg;
   assign DIV_DSR   = dsr_reg;
   assign RSP_V     = (state_reg == RESP);
   assign RSP_ID    = id_reg;
   assign RSP_Q     = q_reg;
   assign RSP_R     = r_reg;
   assign RSP_DZ    = dz_reg;
   assign RSP_TO    = to_reg;
   assign BUSY      = (state_reg != IDLE);

endmodule

// File: tb/tb_srt_div_sched.sv
// Self-checking bench for srt_div_sched: directed scenarios plus randomized requests,
// with a behavioural divider core and a round-robin/arithmetic reference model.
module tb_srt_div_sched;

   localparam int NREQ = 4;
   localparam int W    = 64;
   localparam int TMO  = 200;
   localparam int IDW  = 2;

   logic              CLK = 1'b0;
   logic              RSTN;
   logic [NREQ-1:0]   REQ_V;
   logic [NREQ-1:0]   REQ_RDY;
   logic [NREQ*W-1:0] REQ_DVD;
   logic [NREQ*W-1:0] REQ_DSR;
   logic              DIV_START;
   logic [W-1:0]      DIV_DVD;
   logic [W-1:0]      DIV_DSR;
   logic              DIV_DONE;
   logic [W-1:0]      DIV_Q;
   logic [W-1:0]      DIV_R;
   logic              RSP_V;
   logic              RSP_RDY;
   logic [IDW-1:0]    RSP_ID;
   logic [W-1:0]      RSP_Q;
   logic [W-1:0]      RSP_R;
   logic              RSP_DZ;
   logic              RSP_TO;
   logic              BUSY;

   srt_div_sched #(.NREQ(NREQ), .W(W), .TMO(TMO), .IDW(IDW)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .REQ_V(REQ_V), .REQ_RDY(REQ_RDY), .REQ_DVD(REQ_DVD), .REQ_DSR(REQ_DSR),
      .DIV_START(DIV_START), .DIV_DVD(DIV_DVD), .DIV_DSR(DIV_DSR),
      .DIV_DONE(DIV_DONE), .DIV_Q(DIV_Q), .DIV_R(DIV_R),
      .RSP_V(RSP_V), .RSP_RDY(RSP_RDY), .RSP_ID(RSP_ID), .RSP_Q(RSP_Q), .RSP_R(RSP_R),
      .RSP_DZ(RSP_DZ), .RSP_TO(RSP_TO), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int errors    = 0;
   int checks    = 0;
   int cyc       = 0;
   int start_cnt = 0;
   int core_cnt  = 0;
   int core_lat  = 5;
   int rr_model  = 0;
   logic [W-1:0] core_a, core_b;
   logic [63:0]  op_a [NREQ];
   logic [63:0]  op_b [NREQ];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock, then the behavioural core reacts to what it sees this cycle.
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
      DIV_DONE = 1'b0;
      if (DIV_START === 1'b1) begin
         start_cnt++;
         core_a   = DIV_DVD;
         core_b   = DIV_DSR;
         core_cnt = core_lat;
      end else if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            DIV_DONE = 1'b1;
            DIV_Q    = (core_b != 0) ? core_a / core_b : '1;
            DIV_R    = (core_b != 0) ? core_a % core_b : core_a;
         end
      end
   endtask

   task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
      op_a[i] = a;
      op_b[i] = b;
      REQ_DVD[i*W +: W] = a;
      REQ_DSR[i*W +: W] = b;
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
      for (int k = 0; k < NREQ; k++)
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      return 0;
   endfunction

   // Waits for the grant, follows one transaction to its handshake and checks it.
   task automatic serve(input int exp_id, input int lat, input int rdy_delay, input bit stray,
                        output int g_cyc, output int hs_cyc);
      logic [63:0]     a, b, eq, er;
      logic            edz, eto;
      int              elat, s0;
      bit              found;
      logic [NREQ-1:0] oh;
      a = op_a[exp_id];
      b = op_b[exp_id];
      core_lat = lat;
      found = 1'b0;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (|REQ_RDY) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      g_cyc  = cyc;
      hs_cyc = cyc;
      chk("grant_seen", 64'(found), 64'(1));
      if (!found) return;
      oh = '0;
      oh[exp_id] = 1'b1;
      chk("grant_onehot", 64'(REQ_RDY), 64'(oh));
      rr_model = (exp_id + 1) % NREQ;
      s0 = start_cnt;
      tick();
      chk("issue_rdy_low", 64'(REQ_RDY), 64'(0));
      chk("issue_start", 64'(DIV_START), 64'(b != 0));
      chk("issue_dvd", DIV_DVD, a);
      chk("issue_dsr", DIV_DSR, b);
      found = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (RSP_V === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("rsp_seen", 64'(found), 64'(1));
      if (b == 0) begin
         eq = '1; er = a; edz = 1'b1; eto = 1'b0; elat = 2;
      end else if (lat == 0) begin
         eq = '0; er = '0; edz = 1'b0; eto = 1'b1; elat = 1 + TMO;
      end else begin
         eq = a / b; er = a % b; edz = 1'b0; eto = 1'b0; elat = 2 + lat;
      end
      chk("rsp_id", 64'(RSP_ID), 64'(exp_id));
      chk("rsp_q", RSP_Q, eq);
      chk("rsp_r", RSP_R, er);
      chk("rsp_dz", 64'(RSP_DZ), 64'(edz));
      chk("rsp_to", 64'(RSP_TO), 64'(eto));
      chk("rsp_latency", 64'(cyc - g_cyc), 64'(elat));
      chk("start_count", 64'(start_cnt - s0), 64'(b != 0));
      chk("rsp_busy", 64'(BUSY), 64'(1));
      for (int n = 0; n < rdy_delay; n++) begin
         tick();
         if (stray) begin
            DIV_DONE = 1'b1;
            DIV_Q    = '1;
            DIV_R    = '1;
         end
         chk("hold_v", 64'(RSP_V), 64'(1));
         chk("hold_q", RSP_Q, eq);
         chk("hold_r", RSP_R, er);
         chk("hold_flags", 64'({RSP_DZ, RSP_TO}), 64'({edz, eto}));
         chk("hold_rdy", 64'(REQ_RDY), 64'(0));
      end
      $display("txn id=%0d dvd=%0h dsr=%0h q=%0h r=%0h dz=%0b to=%0b lat=%0d",
               exp_id, a, b, RSP_Q, RSP_R, RSP_DZ, RSP_TO, elat);
      RSP_RDY = 1'b1;
      hs_cyc  = cyc;
      tick();
      RSP_RDY = 1'b0;
      chk("post_hs_v", 64'(RSP_V), 64'(0));
      chk("post_hs_busy", 64'(BUSY), 64'(0));
   endtask

   initial begin
      int              g, h, g2, h2, id;
      logic [NREQ-1:0] mask;
      logic [63:0]     ra, rb;
      RSTN    = 1'b0;
      REQ_V   = '0;
      REQ_DVD = '0;
      REQ_DSR = '0;
      DIV_DONE = 1'b0;
      DIV_Q   = '0;
      DIV_R   = '0;
      RSP_RDY = 1'b0;
      core_a  = '0;
      core_b  = '0;
      repeat (3) tick();
      chk("rst_req_rdy", 64'(REQ_RDY), 64'(0));
      chk("rst_start", 64'(DIV_START), 64'(0));
      chk("rst_rsp_v", 64'(RSP_V), 64'(0));
      chk("rst_busy", 64'(BUSY), 64'(0));
      chk("rst_div_dvd", DIV_DVD, 64'(0));
      chk("rst_rsp_q", RSP_Q, 64'(0));
      chk("rst_rsp_id", 64'(RSP_ID), 64'(0));
      RSTN = 1'b1;
      tick();
      chk("idle_busy", 64'(BUSY), 64'(0));

      // Single request on requester 2: 100 / 7
      set_op(2, 64'd100, 64'd7);
      REQ_V = 4'b0100;
      serve(rr_pick(REQ_V, rr_model), 5, 0, 1'b0, g, h);
      REQ_V = '0;

      // Randomized masks, operands, core latency and consumer back-pressure
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < NREQ; i++) begin
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
               rb = 64'd0;
            else if ($urandom_range(0, 1) == 1)
               rb = {$urandom, $urandom};
            else
               rb = 64'($urandom_range(1, 5000));
            set_op(i, ra, rb);
         end
         mask  = 4'($urandom_range(1, 15));
         REQ_V = mask;
         id    = rr_pick(mask, rr_model);
         serve(id, int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), 1'b0, g, h);
         REQ_V = '0;
      end

      // Fairness from a fresh pointer: all requesters held high
      RSTN = 1'b0;
      tick();
      RSTN = 1'b1;
      rr_model = 0;
      core_cnt = 0;
      tick();
      for (int i = 0; i < NREQ; i++)
         set_op(i, {$urandom, $urandom}, 64'($urandom_range(1, 100000)));
      REQ_V = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         id = rr_pick(REQ_V, rr_model);
         serve(id, 5, 0, 1'b0, g, h);
      end
      REQ_V = '0;

      // Divide by zero on requester 1
      set_op(1, 64'd55, 64'd0);
      REQ_V = 4'b0010;
      serve(rr_pick(REQ_V, rr_model), 5, 0, 1'b0, g, h);
      REQ_V = '0;

      // Core never answers; stray completions during and after the response
      set_op(3, {$urandom, $urandom}, 64'd9);
      REQ_V = 4'b1000;
      serve(rr_pick(REQ_V, rr_model), 0, 3, 1'b1, g, h);
      REQ_V = '0;
      DIV_DONE = 1'b1;
      DIV_Q    = '1;
      DIV_R    = '1;
      tick();
      chk("stray_busy", 64'(BUSY), 64'(0));
      chk("stray_rsp_v", 64'(RSP_V), 64'(0));
      tick();
      chk("stray_start", 64'(DIV_START), 64'(0));

      // Back-pressure for 10 cycles, next grant right after the handshake
      set_op(0, {$urandom, $urandom}, 64'($urandom_range(1, 999)));
      set_op(2, {$urandom, $urandom}, 64'($urandom_range(1, 999)));
      REQ_V = 4'b0101;
      serve(rr_pick(REQ_V, rr_model), 4, 10, 1'b0, g, h);
      serve(rr_pick(REQ_V, rr_model), 3, 0, 1'b0, g2, h2);
      chk("next_grant_cycle", 64'(g2), 64'(h + 1));
      REQ_V = '0;

      // Asynchronous reset while waiting on the core
      set_op(1, {$urandom, $urandom}, 64'($urandom_range(1, 999)));
      REQ_V = 4'b0010;
      core_lat = 50;
      #1;
      chk("pre_rst_grant", 64'(REQ_RDY), 64'(4'b0010));
      tick();
      chk("pre_rst_start", 64'(DIV_START), 64'(1));
      repeat (5) tick();
      chk("pre_rst_busy", 64'(BUSY), 64'(1));
      REQ_V = 4'b1111;
      #3;
      RSTN = 1'b0;
      #1;
      chk("arst_req_rdy", 64'(REQ_RDY), 64'(0));
      chk("arst_start", 64'(DIV_START), 64'(0));
      chk("arst_div_dvd", DIV_DVD, 64'(0));
      chk("arst_div_dsr", DIV_DSR, 64'(0));
      chk("arst_rsp_v", 64'(RSP_V), 64'(0));
      chk("arst_rsp_id", 64'(RSP_ID), 64'(0));
      chk("arst_rsp_q", RSP_Q, 64'(0));
      chk("arst_rsp_r", RSP_R, 64'(0));
      chk("arst_flags", 64'({RSP_DZ, RSP_TO}), 64'(0));
      chk("arst_busy", 64'(BUSY), 64'(0));
      core_cnt = 0;
      repeat (2) tick();
      chk("arst_hold_busy", 64'(BUSY), 64'(0));
      RSTN = 1'b1;
      rr_model = 0;
      for (int i = 0; i < NREQ; i++)
         set_op(i, {$urandom, $urandom}, 64'($urandom_range(1, 100000)));
      serve(rr_pick(REQ_V, rr_model), 5, 0, 1'b0, g, h);
      REQ_V = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
